// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter, paced by the UART's busy status.
// Define UART_TX_FIFO_CTS_EN to add the active-low cts_n flow-control input.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_BITS    = 4,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                wr_stb,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_BITS:0] count,
  output logic                overflow,
  output logic                uart_transmit,
  output logic [7:0]          uart_tx_byte,
  input  logic                uart_is_transmitting
`ifdef UART_TX_FIFO_CTS_EN
  ,
  input  logic                cts_n
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned CW    = DEPTH_BITS + 1;
  localparam int unsigned TW    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  transmit_q, transmit_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  wr_en;
  logic                  pop;
  logic                  cts_ok;

`ifdef UART_TX_FIFO_CTS_EN
  assign cts_ok = ~cts_n;
`else
  assign cts_ok = 1'b1;
`endif

  // Next-state: launch FSM, then pointer/count bookkeeping, then clear override.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !uart_is_transmitting && cts_ok) begin
          pop        = 1'b1;
          transmit_d = 1'b1;
          tx_byte_d  = mem_q[rd_ptr_q];
          timer_d    = '0;
          state_d    = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        // A UART that never goes busy (e.g. reset mid-launch) must not hang us.
        if (uart_is_transmitting) begin
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase

    wr_en      = wr_stb && !full_q && !clear;
    overflow_d = wr_stb && full_q && !clear;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (clear) begin
      wr_en    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // Storage array needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full          = full_q;
  assign empty         = empty_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign uart_transmit = transmit_q;
  assign uart_tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       busy;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
`ifdef UART_TX_FIFO_CTS_EN
  logic       cts_n;
`endif

  int         n_vec;
  int         n_err;
  int         n_launch;
  int         uart_rem;
  bit         tx_prev;
  logic [7:0] last_byte;
  logic [7:0] ref_q[$];

  uart_tx_fifo dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .clear                (clear),
    .wr_stb               (wr_stb),
    .wr_data              (wr_data),
    .full                 (full),
    .empty                (empty),
    .count                (count),
    .overflow             (overflow),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (busy)
`ifdef UART_TX_FIFO_CTS_EN
    ,
    .cts_n                (cts_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare against the queue model.
  task automatic step(input logic wr, input logic [7:0] d, input logic clr, output bit launched);
    bit full_pre;
    bit busy_pre;
`ifdef UART_TX_FIFO_CTS_EN
    bit cts_pre;
    cts_pre = cts_n;
`endif
    full_pre = (ref_q.size() == DEPTH);
    busy_pre = busy;
    wr_stb   = wr;
    wr_data  = d;
    clear    = clr;
    @(posedge clk);
    @(negedge clk);
    launched = uart_transmit;
    chk("tx_single_cycle", 32'(uart_transmit & tx_prev), 32'(0));
    tx_prev = uart_transmit;
    if (uart_transmit) begin
      n_launch++;
      chk("launch_nonempty", 32'(ref_q.size() != 0), 32'(1));
      chk("launch_not_busy", 32'(busy_pre), 32'(0));
`ifdef UART_TX_FIFO_CTS_EN
      chk("launch_cts", 32'(cts_pre), 32'(0));
`endif
      if (ref_q.size() != 0) last_byte = ref_q.pop_front();
      chk("tx_byte", 32'(uart_tx_byte), 32'(last_byte));
    end else begin
      chk("tx_byte_hold", 32'(uart_tx_byte), 32'(last_byte));
    end
    if (clr) ref_q.delete();
    else if (wr && !full_pre) ref_q.push_back(d);
    chk("overflow", 32'(overflow), 32'(wr && full_pre && !clr));
    chk("count", 32'(count), 32'(ref_q.size()));
    chk("full", 32'(full), 32'(ref_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(ref_q.size() == 0));
    wr_stb = 1'b0;
    clear  = 1'b0;
  endtask

  // Random traffic with a UART model that usually goes busy for a while after a launch.
  task automatic run(input int n, input int wr_pct, input int clr_pct);
    bit l;
    for (int i = 0; i < n; i++) begin
      step(($urandom_range(0, 99) < wr_pct), 8'($urandom), ($urandom_range(0, 99) < clr_pct), l);
      if (uart_rem > 0) uart_rem--;
      if (l && ($urandom_range(0, 9) != 0)) uart_rem = int'($urandom_range(2, 8));
      busy = (uart_rem != 0);
    end
  endtask

  initial begin
    bit l;
    int nl0;
    int idx1;
    int idx2;
    n_vec     = 0;
    n_err     = 0;
    n_launch  = 0;
    uart_rem  = 0;
    tx_prev   = 1'b0;
    last_byte = 8'h00;
    rst_n     = 1'b0;
    clear     = 1'b0;
    wr_stb    = 1'b0;
    wr_data   = 8'h00;
    busy      = 1'b0;
`ifdef UART_TX_FIFO_CTS_EN
    cts_n     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_transmit", 32'(uart_transmit), 32'(0));
    chk("rst_tx_byte", 32'(uart_tx_byte), 32'(0));
    rst_n = 1'b1;

    // Single byte: write at edge 0, launch at edge 1.
    step(1'b1, 8'h55, 1'b0, l);
    chk("t1_no_launch_edge0", 32'(l), 32'(0));
    step(1'b0, 8'h00, 1'b0, l);
    chk("t1_launch_edge1", 32'(l), 32'(1));
    chk("t1_byte", 32'(uart_tx_byte), 32'(8'h55));
    run(12, 0, 0);

    // Burst to full while busy, one dropped write, then drain in order.
    busy = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, l);
    chk("t2_full", 32'(full), 32'(1));
    chk("t2_count16", 32'(count), 32'(16));
    step(1'b1, 8'hAA, 1'b0, l);
    chk("t2_overflow", 32'(overflow), 32'(1));
    nl0 = n_launch;
    run(400, 0, 0);
    chk("t2_launches", 32'(n_launch - nl0), 32'(16));
    chk("t2_drained", 32'(count), 32'(0));
    run(12, 0, 0);

    // Write while full in the same cycle as a pop.
    busy = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i + 32), 1'b0, l);
    busy = 1'b0;
    step(1'b1, 8'h12, 1'b0, l);
    chk("t3_launch", 32'(l), 32'(1));
    chk("t3_overflow", 32'(overflow), 32'(1));
    chk("t3_count15", 32'(count), 32'(15));
    run(400, 0, 0);
    run(12, 0, 0);

    // UART never goes busy: start timeout returns to idle and relaunches.
    busy = 1'b1;
    step(1'b1, 8'hA1, 1'b0, l);
    step(1'b1, 8'hB2, 1'b0, l);
    busy = 1'b0;
    idx1 = -1;
    idx2 = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00, 1'b0, l);
      if (l) begin
        if (idx1 < 0) idx1 = i;
        else if (idx2 < 0) idx2 = i;
      end
    end
    chk("t4_first_launch", 32'(idx1), 32'(0));
    chk("t4_relaunch_window", 32'(idx2 >= 4 && idx2 <= 8), 32'(1));
    chk("t4_count", 32'(count), 32'(0));
    run(12, 0, 0);

    // Clear with a simultaneous write.
    busy = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 8'h60), 1'b0, l);
    step(1'b1, 8'h77, 1'b1, l);
    chk("t5_count", 32'(count), 32'(0));
    chk("t5_empty", 32'(empty), 32'(1));
    chk("t5_no_overflow", 32'(overflow), 32'(0));
    nl0 = n_launch;
    run(30, 0, 0);
    chk("t5_no_launch", 32'(n_launch - nl0), 32'(0));

`ifdef UART_TX_FIFO_CTS_EN
    // Flow control holds a byte until cts_n drops.
    run(12, 0, 0);
    cts_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, l);
    nl0 = n_launch;
    for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 1'b0, l);
    chk("t6_held", 32'(n_launch - nl0), 32'(0));
    cts_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, l);
    chk("t6_launch", 32'(l), 32'(1));
    chk("t6_byte", 32'(uart_tx_byte), 32'(8'h3C));
    run(20, 0, 0);
`endif

    run(600, 40, 2);

    // Asynchronous reset in the middle of traffic.
    run(10, 70, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'(0));
    chk("mid_rst_empty", 32'(empty), 32'(1));
    chk("mid_rst_transmit", 32'(uart_transmit), 32'(0));
    chk("mid_rst_tx_byte", 32'(uart_tx_byte), 32'(0));
    ref_q.delete();
    last_byte = 8'h00;
    uart_rem  = 0;
    busy      = 1'b0;
    tx_prev   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(300, 40, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
